// File: rtl/mux_pkg.sv
// Shared types and default sizes for the mux_demux_stream packet demultiplexer.
// MUX_DEMUX_DROP_EN adds the ST_DROP state used to swallow out-of-range packets.
package mux_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned NUM_OUT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PKT
`ifdef MUX_DEMUX_DROP_EN
    ,
    ST_DROP
`endif
  } state_e;

endpackage

// File: rtl/mux_hold_reg.sv
// One-entry valid/ready pipeline register; accepts a new entry in the same cycle
// the current one drains, so a full/ready stream sustains one beat per cycle.
module mux_hold_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  assign o_ready = !r_full || i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_ready) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_demux_stream.sv
// Registered 1-to-NUM_OUT packet demux; the destination is latched on the first beat.
// Optional MUX_DEMUX_DROP_EN: out-of-range packets are discarded and flagged on drop_err.
module mux_demux_stream
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NUM_OUT = NUM_OUT_DEF,
  parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  input  logic [SEL_W-1:0]   s_sel,
  output logic [NUM_OUT-1:0] m_valid,
  input  logic [NUM_OUT-1:0] m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic               busy
`ifdef MUX_DEMUX_DROP_EN
  ,
  output logic               drop_err
`endif
);

  localparam int unsigned HoldW = 1 + SEL_W + DATA_W;

  state_e r_state_q, w_state_d;

  logic [SEL_W-1:0]  r_pkt_dest;
  logic [SEL_W-1:0]  w_sel_clamp;
  logic [SEL_W-1:0]  w_beat_dest;
  logic              w_sel_oor;
  logic              w_drop_beat;
  logic              w_accept;
  logic              w_load;
  logic              w_hold_in_ready;
  logic              w_hold_full;
  logic              w_out_ready;
  logic [HoldW-1:0]  w_hold_out;
  logic              w_hold_last;
  logic [SEL_W-1:0]  w_hold_dest;
  logic [DATA_W-1:0] w_hold_data;

  assign w_sel_oor   = (32'(s_sel) >= NUM_OUT);
  assign w_sel_clamp = w_sel_oor ? SEL_W'(NUM_OUT - 1) : s_sel;
  assign w_beat_dest = (r_state_q == ST_IDLE) ? w_sel_clamp : r_pkt_dest;

`ifdef MUX_DEMUX_DROP_EN
  logic r_drop_err, w_drop_err_d;

  // Dropped beats bypass the holding register, so they never wait on m_ready.
  assign w_drop_beat = (r_state_q == ST_DROP) || ((r_state_q == ST_IDLE) && w_sel_oor);
  assign drop_err    = r_drop_err;
`else
  assign w_drop_beat = 1'b0;
`endif

  assign s_ready  = w_drop_beat || w_hold_in_ready;
  assign w_accept = s_valid && s_ready;
  assign w_load   = w_accept && !w_drop_beat;

  always_comb begin
    w_state_d = r_state_q;
`ifdef MUX_DEMUX_DROP_EN
    w_drop_err_d = 1'b0;
`endif
    unique case (r_state_q)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef MUX_DEMUX_DROP_EN
          if (w_sel_oor) begin
            if (s_last) w_drop_err_d = 1'b1;
            else        w_state_d    = ST_DROP;
          end else
`endif
          if (!s_last) w_state_d = ST_PKT;
        end
      end
      ST_PKT: begin
        if (w_accept && s_last) w_state_d = ST_IDLE;
      end
`ifdef MUX_DEMUX_DROP_EN
      ST_DROP: begin
        if (w_accept && s_last) begin
          w_state_d    = ST_IDLE;
          w_drop_err_d = 1'b1;
        end
      end
`endif
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= ST_IDLE;
      r_pkt_dest <= '0;
`ifdef MUX_DEMUX_DROP_EN
      r_drop_err <= 1'b0;
`endif
    end else begin
      r_state_q <= w_state_d;
      if (w_accept && (r_state_q == ST_IDLE)) r_pkt_dest <= w_sel_clamp;
`ifdef MUX_DEMUX_DROP_EN
      r_drop_err <= w_drop_err_d;
`endif
    end
  end

  // Each beat carries its own dest so a new packet can load while the old one drains.
  mux_hold_reg #(
    .W (HoldW)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_valid (s_valid && w_load),
    .o_ready (w_hold_in_ready),
    .i_data  ({s_last, w_beat_dest, s_data}),
    .o_valid (w_hold_full),
    .i_ready (w_out_ready),
    .o_data  (w_hold_out)
  );

  assign {w_hold_last, w_hold_dest, w_hold_data} = w_hold_out;

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      m_valid[i] = w_hold_full && (w_hold_dest == SEL_W'(i));
    end
  end

  // Only the selected port's ready matters, since m_valid is one-hot.
  assign w_out_ready = |(m_valid & m_ready);
  assign m_data      = w_hold_data;
  assign m_last      = w_hold_last;
  assign busy        = (r_state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_demux_stream.sv
// Scoreboard bench for mux_demux_stream: a 4-port instance for the main traffic and a
// 3-port instance for out-of-range selects (with or without MUX_DEMUX_DROP_EN).
module tb_mux_demux_stream;

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic [1:0] s_sel = '0;
  logic [3:0] m_valid;
  logic [3:0] m_ready = 4'hF;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;

  logic       s3_valid = 1'b0;
  logic       s3_ready;
  logic [7:0] s3_data = '0;
  logic       s3_last = 1'b0;
  logic [1:0] s3_sel = '0;
  logic [2:0] m3_valid;
  logic [2:0] m3_ready = 3'b111;
  logic [7:0] m3_data;
  logic       m3_last;
  logic       busy3;

`ifdef MUX_DEMUX_DROP_EN
  logic drop_err;
  logic drop_err3;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t q3[$];
  logic tb_open = 1'b0;
  int   tb_port = 0;

  always #5 clk = ~clk;

  mux_demux_stream #(
    .DATA_W  (8),
    .NUM_OUT (4)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_sel   (s_sel),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy)
`ifdef MUX_DEMUX_DROP_EN
    ,
    .drop_err (drop_err)
`endif
  );

  mux_demux_stream #(
    .DATA_W  (8),
    .NUM_OUT (3)
  ) u_dut3 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s3_valid),
    .s_ready (s3_ready),
    .s_data  (s3_data),
    .s_last  (s3_last),
    .s_sel   (s3_sel),
    .m_valid (m3_valid),
    .m_ready (m3_ready),
    .m_data  (m3_data),
    .m_last  (m3_last),
    .busy    (busy3)
`ifdef MUX_DEMUX_DROP_EN
    ,
    .drop_err (drop_err3)
`endif
  );

  // Scoreboards: every output handshake must match the oldest accepted beat.
  always @(negedge clk) begin
    if (|(m_valid & m_ready)) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb4_unexpected: got valid=%b data=%h, expected no beat", m_valid, m_data);
      end else begin
        e = q.pop_front();
        if (m_valid !== (4'd1 << e.port) || m_data !== e.data || m_last !== e.last) begin
          n_err++;
          $display("FAIL sb4_beat: got valid=%b data=%h last=%b, expected valid=%b data=%h last=%b",
                   m_valid, m_data, m_last, 4'd1 << e.port, e.data, e.last);
        end
      end
    end
    if (|(m3_valid & m3_ready)) begin
      exp_t e;
      n_cmp++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL sb3_unexpected: got valid=%b data=%h, expected no beat", m3_valid, m3_data);
      end else begin
        e = q3.pop_front();
        if (m3_valid !== (3'd1 << e.port) || m3_data !== e.data || m3_last !== e.last) begin
          n_err++;
          $display("FAIL sb3_beat: got valid=%b data=%h last=%b, expected valid=%b data=%h last=%b",
                   m3_valid, m3_data, m3_last, 3'd1 << e.port, e.data, e.last);
        end
      end
    end
  end

  task automatic sb_push(input logic [7:0] d, input logic l, input logic [1:0] sel);
    exp_t e;
    if (!tb_open) tb_port = int'(sel);
    tb_open = !l;
    e.port = tb_port;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  // Present a beat and wait (bounded) until it will be accepted at the next edge.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic [1:0] sel);
    int guard = 0;
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_sel   = sel;
    @(negedge clk);
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, guard);
    end else begin
      sb_push(d, l, sel);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 4'b0 || m_data !== 8'h00 || m_last !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b busy=%b, expected all 0",
               m_valid, m_data, m_last, busy);
    end
    n_cmp++;
    if (m3_valid !== 3'b0 || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs3: got valid=%b busy=%b, expected 0", m3_valid, busy3);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_s_ready: got %b, expected 1", s_ready);
    end
  endtask

  task automatic test_single_packet();
    send_beat(8'h11, 1'b0, 2'd2);
    send_beat(8'h22, 1'b0, 2'd0);
    n_cmp++;
    if (m_valid !== 4'b0100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_c1: got valid=%b busy=%b, expected 0100 1", m_valid, busy);
    end
    send_beat(8'h33, 1'b1, 2'd0);
    n_cmp++;
    if (m_valid !== 4'b0100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_c2: got valid=%b busy=%b, expected 0100 1", m_valid, busy);
    end
    idle();
    n_cmp++;
    if (m_valid !== 4'b0100 || m_last !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_c3: got valid=%b last=%b busy=%b, expected 0100 1 0",
               m_valid, m_last, busy);
    end
    idle();
    n_cmp++;
    if (m_valid !== 4'b0000) begin
      n_err++;
      $display("FAIL single_drain: got valid=%b, expected 0000", m_valid);
    end
  endtask

  task automatic test_sel_change();
    send_beat(8'h31, 1'b0, 2'd1);
    send_beat(8'h32, 1'b0, 2'd3);
    send_beat(8'h33, 1'b1, 2'd3);
    n_cmp++;
    if (m_valid !== 4'b0010) begin
      n_err++;
      $display("FAIL selchg_route: got valid=%b, expected 0010", m_valid);
    end
    idle();
    n_cmp++;
    if (m_valid !== 4'b0010 || m_data !== 8'h33) begin
      n_err++;
      $display("FAIL selchg_last: got valid=%b data=%h, expected 0010 33", m_valid, m_data);
    end
    idle();
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1;
    m_ready = 4'b1110;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    s_last  = 1'b0;
    s_sel   = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first_ready: got %b, expected 1", s_ready);
    end
    sb_push(8'hA5, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) s_data = 8'hA6;
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 1'b0 || m_data !== 8'hA5 || m_valid !== 4'b0001) begin
        n_err++;
        $display("FAIL bp_stall%0d: got s_ready=%b data=%h valid=%b, expected 0 a5 0001",
                 k, s_ready, m_data, m_valid);
      end
    end
    @(posedge clk);
    #1;
    m_ready = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got s_ready=%b, expected 1", s_ready);
    end
    sb_push(8'hA6, 1'b0, 2'd0);
    send_beat(8'hA7, 1'b1, 2'd0);
    idle();
    idle();
  endtask

  task automatic test_back_to_back();
    send_beat(8'h40, 1'b1, 2'd0);
    send_beat(8'h41, 1'b1, 2'd1);
    n_cmp++;
    if (m_valid !== 4'b0001) begin
      n_err++;
      $display("FAIL b2b_0: got valid=%b, expected 0001", m_valid);
    end
    send_beat(8'h42, 1'b1, 2'd2);
    n_cmp++;
    if (m_valid !== 4'b0010) begin
      n_err++;
      $display("FAIL b2b_1: got valid=%b, expected 0010", m_valid);
    end
    send_beat(8'h43, 1'b1, 2'd3);
    n_cmp++;
    if (m_valid !== 4'b0100) begin
      n_err++;
      $display("FAIL b2b_2: got valid=%b, expected 0100", m_valid);
    end
    idle();
    n_cmp++;
    if (m_valid !== 4'b1000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_3: got valid=%b busy=%b, expected 1000 0", m_valid, busy);
    end
    idle();
  endtask

  task automatic test_reset_mid_packet();
    send_beat(8'h50, 1'b0, 2'd2);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    s_data = 8'h51;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    tb_open = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 4'b0000 || busy !== 1'b0 || m_last !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_clear: got valid=%b busy=%b last=%b, expected 0000 0 0",
               m_valid, busy, m_last);
    end
    send_beat(8'h60, 1'b1, 2'd1);
    idle();
    n_cmp++;
    if (m_valid !== 4'b0010 || m_data !== 8'h60) begin
      n_err++;
      $display("FAIL rstmid_next: got valid=%b data=%h, expected 0010 60", m_valid, m_data);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    exp_t e;
    @(posedge clk);
    #1;
    s3_valid = 1'b1;
    s3_data  = 8'h77;
    s3_last  = 1'b0;
    s3_sel   = 2'd3;
    @(negedge clk);
    n_cmp++;
    if (s3_ready !== 1'b1) begin
      n_err++;
      $display("FAIL oor_ready0: got %b, expected 1", s3_ready);
    end
`ifndef MUX_DEMUX_DROP_EN
    e.port = 2; e.data = 8'h77; e.last = 1'b0;
    q3.push_back(e);
`endif
    @(posedge clk);
    #1;
    s3_data = 8'h78;
    s3_last = 1'b1;
    s3_sel  = 2'd0;
    @(negedge clk);
    n_cmp++;
    if (s3_ready !== 1'b1 || busy3 !== 1'b1) begin
      n_err++;
      $display("FAIL oor_ready1: got s_ready=%b busy=%b, expected 1 1", s3_ready, busy3);
    end
`ifdef MUX_DEMUX_DROP_EN
    n_cmp++;
    if (m3_valid !== 3'b000) begin
      n_err++;
      $display("FAIL oor_drop_valid: got %b, expected 000", m3_valid);
    end
`else
    n_cmp++;
    if (m3_valid !== 3'b100) begin
      n_err++;
      $display("FAIL oor_port: got %b, expected 100", m3_valid);
    end
    e.port = 2; e.data = 8'h78; e.last = 1'b1;
    q3.push_back(e);
`endif
    @(posedge clk);
    #1;
    s3_valid = 1'b0;
    s3_last  = 1'b0;
    @(negedge clk);
`ifdef MUX_DEMUX_DROP_EN
    n_cmp++;
    if (drop_err3 !== 1'b1 || busy3 !== 1'b0 || m3_valid !== 3'b000) begin
      n_err++;
      $display("FAIL oor_drop_err: got drop_err=%b busy=%b valid=%b, expected 1 0 000",
               drop_err3, busy3, m3_valid);
    end
`else
    n_cmp++;
    if (m3_valid !== 3'b100 || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL oor_last: got valid=%b busy=%b, expected 100 0", m3_valid, busy3);
    end
`endif
    @(posedge clk);
    @(negedge clk);
`ifdef MUX_DEMUX_DROP_EN
    n_cmp++;
    if (drop_err3 !== 1'b0) begin
      n_err++;
      $display("FAIL oor_drop_pulse: got drop_err=%b, expected 0", drop_err3);
    end
`endif
    n_cmp++;
    if (m3_valid !== 3'b000) begin
      n_err++;
      $display("FAIL oor_drain: got valid=%b, expected 000", m3_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_sel_change();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_out_of_range();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0 || q3.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d/%0d pending beats, expected 0/0", q.size(), q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
